// File: rtl/l2_data_sram_ctrl.sv
// L2 data-array bank controller: zero-fills a single-port SRAM after reset, then
// round-robin arbitrates refill (port 0) and core (port 1) accesses onto it.
module l2_data_sram_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 256,
  parameter int SW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          init_req_i,
  output logic          init_done_o,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic          req0_we_i,
  input  logic [AW-1:0] req0_addr_i,
  input  logic [DW-1:0] req0_wdata_i,
  input  logic [SW-1:0] req0_wstrb_i,
  output logic          rsp0_valid_o,
  output logic [DW-1:0] rsp0_rdata_o,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic          req1_we_i,
  input  logic [AW-1:0] req1_addr_i,
  input  logic [DW-1:0] req1_wdata_i,
  input  logic [SW-1:0] req1_wstrb_i,
  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp1_rdata_o,
  output logic          sram_cs_o,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_wdata_o,
  output logic [SW-1:0] sram_wstrb_o,
  input  logic [DW-1:0] sram_rdata_i
);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          ptr;
  logic          rd_pend;
  logic          rd_id;
  logic          run;
  logic          sweep;
  logic          gnt0;
  logic          gnt1;

  assign run   = (state == RUN);
  // Held off while reset is asserted so the array sees no writes until release.
  assign sweep = (state == INIT) && !rst_i;

  // Ties go to the pointer; a lone requester always wins.
  assign gnt0 = run & req0_valid_i & (~req1_valid_i | ~ptr);
  assign gnt1 = run & req1_valid_i & (~req0_valid_i | ptr);

  assign init_done_o  = run;
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wstrb_o = '0;
    if (sweep) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = cnt;
      sram_wstrb_o = '1;
    end else if (gnt0) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = req0_we_i;
      sram_addr_o  = req0_addr_i;
      sram_wdata_o = req0_wdata_i;
      sram_wstrb_o = req0_wstrb_i;
    end else if (gnt1) begin
      sram_cs_o    = 1'b1;
      sram_we_o    = req1_we_i;
      sram_addr_o  = req1_addr_i;
      sram_wdata_o = req1_wdata_i;
      sram_wstrb_o = req1_wstrb_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= INIT;
      cnt     <= '0;
      ptr     <= 1'b0;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      rd_pend <= (gnt0 & ~req0_we_i) | (gnt1 & ~req1_we_i);
      rd_id   <= gnt1;
      if (gnt0)      ptr <= 1'b1;
      else if (gnt1) ptr <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) state <= RUN;
        end
        RUN: begin
          // A grant in this same cycle still completes; its response lands in INIT.
          if (init_req_i) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Response stage: SRAM data arrives the cycle after the read grant.
  assign rsp0_valid_o = rd_pend & ~rd_id;
  assign rsp1_valid_o = rd_pend & rd_id;
  assign rsp0_rdata_o = sram_rdata_i;
  assign rsp1_rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_l2_data_sram_ctrl.sv
// Directed bench for l2_data_sram_ctrl with a behavioural byte-strobed SRAM.
module tb_l2_data_sram_ctrl;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  localparam int DW = 256;
  localparam int SW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          init_req_i;
  logic          init_done_o;
  logic          req0_valid_i, req0_ready_o, req0_we_i;
  logic [AW-1:0] req0_addr_i;
  logic [DW-1:0] req0_wdata_i;
  logic [SW-1:0] req0_wstrb_i;
  logic          rsp0_valid_o;
  logic [DW-1:0] rsp0_rdata_o;
  logic          req1_valid_i, req1_ready_o, req1_we_i;
  logic [AW-1:0] req1_addr_i;
  logic [DW-1:0] req1_wdata_i;
  logic [SW-1:0] req1_wstrb_i;
  logic          rsp1_valid_o;
  logic [DW-1:0] rsp1_rdata_o;
  logic          sram_cs_o, sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [SW-1:0] sram_wstrb_o;
  logic [DW-1:0] sram_rdata_i;

  logic [DW-1:0] mem [DEPTH];
  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] pat_p, d0, d1, exp_lo;

  always #5 clk_i = ~clk_i;

  l2_data_sram_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SW(SW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .init_req_i(init_req_i), .init_done_o(init_done_o),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i), .req0_wstrb_i(req0_wstrb_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i), .req1_wstrb_i(req1_wstrb_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o),
    .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wdata_o(sram_wdata_o), .sram_wstrb_o(sram_wstrb_o), .sram_rdata_i(sram_rdata_i)
  );

  // Single-port SRAM: byte-strobed write, registered read.
  always @(posedge clk_i) begin
    if (sram_cs_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < SW; b++)
          if (sram_wstrb_o[b]) mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic sweep_chk(input int i, input string tag);
    chk(tag, {sram_cs_o, sram_we_o, sram_addr_o, sram_wstrb_o, (sram_wdata_o == '0),
              req0_ready_o, req1_ready_o, init_done_o},
        {1'b1, 1'b1, 9'(i), 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic set0(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    req0_valid_i = v; req0_we_i = we; req0_addr_i = a; req0_wdata_i = wd; req0_wstrb_i = ws;
  endtask

  task automatic set1(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    req1_valid_i = v; req1_we_i = we; req1_addr_i = a; req1_wdata_i = wd; req1_wstrb_i = ws;
  endtask

  initial begin
    int prev;
    pat_p = {8{32'hA5C3_1E77}};
    pat_p[63:0] = 64'h0123_4567_89AB_CDEF;
    d0 = {8{32'h1111_2222}} ^ 256'h1;
    d1 = {8{32'h3333_4444}} ^ 256'h2;
    exp_lo = '0;
    exp_lo[63:0] = pat_p[63:0];

    rst_i = 1'b1; init_req_i = 1'b0;
    set0(1'b1, 1'b0, 9'd3, '0, '0);
    set1(1'b1, 1'b0, 9'd4, '0, '0);
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_state", {sram_cs_o, init_done_o, req0_ready_o, req1_ready_o,
                        rsp0_valid_o, rsp1_valid_o}, 6'b0);

    // Power-up sweep with both requesters pending
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1 sweep_chk(i, "init_sweep");
      @(negedge clk_i);
    end
    set0(1'b0, 1'b0, '0, '0, '0);
    set1(1'b0, 1'b0, '0, '0, '0);
    #1;
    chk("init_done_513", {init_done_o, sram_cs_o}, 2'b10);

    // Partial write then read on port 1
    @(negedge clk_i);
    set1(1'b1, 1'b1, 9'h1A5, pat_p, 32'h0000_00FF);
    #1 chk("wr1_grant", {req1_ready_o, req0_ready_o, sram_cs_o, sram_we_o, sram_addr_o, sram_wstrb_o},
           {1'b1, 1'b0, 1'b1, 1'b1, 9'h1A5, 32'h0000_00FF});
    @(negedge clk_i);
    set1(1'b1, 1'b0, 9'h1A5, '0, 32'h0000_00FF);
    #1 chk("rd1_grant", {req1_ready_o, sram_cs_o, sram_we_o, sram_wstrb_o, rsp1_valid_o},
           {1'b1, 1'b1, 1'b0, 32'h0000_00FF, 1'b0});
    @(negedge clk_i);
    set1(1'b0, 1'b0, '0, '0, '0);
    #1 chk("rd1_rsp_valid", {rsp1_valid_o, rsp0_valid_o}, 2'b10);
    chk("rd1_rsp_data", rsp1_rdata_o, exp_lo);

    // Preload two entries: port 0 then port 1 (pointer ends at 0)
    @(negedge clk_i);
    set0(1'b1, 1'b1, 9'd10, d0, '1);
    @(negedge clk_i);
    set0(1'b0, 1'b0, '0, '0, '0);
    set1(1'b1, 1'b1, 9'd11, d1, '1);
    @(negedge clk_i);
    set1(1'b0, 1'b0, '0, '0, '0);

    // Contention: both valid for 6 cycles
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      set0(1'b1, 1'b0, 9'd10, '0, '0);
      set1(1'b1, 1'b0, 9'd11, '0, '0);
      #1 chk("contend_grant", {req0_ready_o, req1_ready_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) begin
        chk("contend_rsp_route", {rsp0_valid_o, rsp1_valid_o}, (prev == 0) ? 2'b10 : 2'b01);
        chk("contend_rsp_data", (prev == 0) ? rsp0_rdata_o : rsp1_rdata_o, (prev == 0) ? d0 : d1);
      end
      prev = i % 2;
    end
    @(negedge clk_i);
    set0(1'b0, 1'b0, '0, '0, '0);
    set1(1'b0, 1'b0, '0, '0, '0);
    #1 chk("contend_last_rsp", {rsp0_valid_o, rsp1_valid_o}, 2'b01);
    chk("contend_last_data", rsp1_rdata_o, d1);

    // Move the pointer to 1, then port 1 alone for 4 cycles
    @(negedge clk_i);
    set0(1'b1, 1'b0, 9'd10, '0, '0);
    #1 chk("solo0_grant", {req0_ready_o, req1_ready_o}, 2'b10);
    @(negedge clk_i);
    set0(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      set1(1'b1, 1'b0, 9'd11, '0, '0);
      #1 chk("solo1_grant", {req0_ready_o, req1_ready_o}, 2'b01);
    end
    @(negedge clk_i);
    set0(1'b1, 1'b0, 9'd10, '0, '0);
    #1 chk("after_solo_favours0", {req0_ready_o, req1_ready_o}, 2'b10);
    @(negedge clk_i);
    set0(1'b0, 1'b0, '0, '0, '0);
    set1(1'b0, 1'b0, '0, '0, '0);
    #1 chk("after_solo_rsp", {rsp0_valid_o, rsp1_valid_o}, 2'b10);
    chk("after_solo_data", rsp0_rdata_o, d0);

    // Re-init while a port-0 read is granted
    @(negedge clk_i);
    set0(1'b1, 1'b0, 9'd11, '0, '0);
    init_req_i = 1'b1;
    #1 chk("reinit_grant", {req0_ready_o, init_done_o}, 2'b11);
    @(negedge clk_i);
    set0(1'b0, 1'b0, '0, '0, '0);
    init_req_i = 1'b0;
    #1 chk("reinit_rsp", {rsp0_valid_o, rsp1_valid_o}, 2'b10);
    chk("reinit_rsp_data", rsp0_rdata_o, d1);
    sweep_chk(0, "reinit_sweep");
    for (int i = 1; i < DEPTH; i++) begin
      @(negedge clk_i);
      init_req_i = (i == 100);
      #1 sweep_chk(i, "reinit_sweep");
    end
    @(negedge clk_i);
    init_req_i = 1'b0;
    #1 chk("reinit_done", init_done_o, 1'b1);
    set1(1'b1, 1'b0, 9'd10, '0, '0);
    @(negedge clk_i);
    set1(1'b0, 1'b0, '0, '0, '0);
    #1 chk("reinit_zero_valid", rsp1_valid_o, 1'b1);
    chk("reinit_zero_data", rsp1_rdata_o, '0);

    // Async reset with a read response pending
    @(negedge clk_i);
    set0(1'b1, 1'b0, 9'd11, '0, '0);
    #1 chk("rst_rd_grant", req0_ready_o, 1'b1);
    @(posedge clk_i);
    #1 chk("rst_rd_pending", rsp0_valid_o, 1'b1);
    set0(1'b0, 1'b0, '0, '0, '0);
    rst_i = 1'b1;
    #1 chk("rst_rd_cleared", {rsp0_valid_o, rsp1_valid_o, sram_cs_o, init_done_o}, 4'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 sweep_chk(i, "rst_rd_sweep");
      @(negedge clk_i);
    end

    // Async reset mid-sweep, then a full sweep from 0
    #1 sweep_chk(5, "pre_midsweep_rst");
    rst_i = 1'b1;
    #1 chk("midsweep_rst_cs", {sram_cs_o, init_done_o, rsp0_valid_o, rsp1_valid_o}, 4'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1 sweep_chk(i, "restart_sweep");
      @(negedge clk_i);
    end
    #1 chk("restart_done", init_done_o, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/l2_data_sram_ctrl.md
# l2_data_sram_ctrl

Controller for one L2 data-array bank built from a 512-entry x 256-bit single-port SRAM with 32 byte-write strobes. After reset it zero-fills every entry. It then shares the single port between two requesters under round-robin arbitration: port 0 is the refill path and port 1 is the core access path. It returns read data one cycle after grant and sits between the L2 control pipeline and the data SRAM bank.

## Interface
- DEPTH, 512, number of SRAM entries
- AW, 9, address width (log2 DEPTH)
- DW, 256, data width
- SW, 32, strobe width (DW/8)

- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- init_req_i  in  1  pulse: re-run zero-fill sweep
- init_done_o  out  1  high when the array is initialised and requests are accepted
- reqN_valid_i (N=0,1)  in  1  request valid
- reqN_ready_o  out  1  request accepted this cycle
- reqN_we_i  in  1  1 = write, 0 = read
- reqN_addr_i  in  AW  entry address
- reqN_wdata_i  in  DW  write data
- reqN_wstrb_i  in  SW  byte-write enables
- rspN_valid_o  out  1  read data valid
- rspN_rdata_o  out  DW  read data
- sram_cs_o  out  1  SRAM chip select
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AW  SRAM address
- sram_wdata_o  out  DW  SRAM write data
- sram_wstrb_o  out  SW  SRAM byte strobes
- sram_rdata_i  in  DW  SRAM read data, valid the cycle after a read cs

## Operation
- **States:** INIT and RUN. Reset enters INIT with init counter = 0.
- **INIT:**
  - Every cycle drives cs=1, we=1, addr=counter, wdata=0, wstrb=all ones, then counter+1.
  - The write at counter DEPTH-1 is the last; the next state is RUN.
  - reqN_ready_o=0 and rspN_valid_o=0 throughout.
- **RUN:**
  - init_done_o=1.
  - init_req_i=1 in RUN returns to INIT with counter=0 at the next edge. A request granted in that same cycle still completes, and its read response is still delivered.
  - init_req_i is ignored while in INIT.
- **Arbitration** (combinational, RUN only):
  - One valid requester is granted.
  - Two valid requesters: the one equal to the priority pointer is granted.
  - The pointer resets to 0. After any grant it becomes the non-granted index. With no grant it holds.
- **Grant:** reqN_ready_o=1 for the winner only. SRAM outputs take the winner's we/addr/wdata/wstrb with cs=1. With no grant, cs=0 and the other SRAM outputs are don't-care (drive 0).
- **Strobes on reads:** wstrb is forwarded unchanged. The SRAM ignores strobes when we=0.
- **Read response:** registered rd_pend/rd_id capture a read grant. The next cycle, rsp[rd_id]_valid_o=1 and rspN_rdata_o=sram_rdata_i (combinational pass-through, both ports).
- **Responses:** no response backpressure. Writes produce no response.
- **Write ordering:** a write grant takes effect at the clock edge. A read of the same address granted the next cycle returns the new data.

## Timing
- **Reset values:** init_done_o=0, all ready/rsp_valid=0, sram_cs_o=0 during reset assertion. The first INIT write is in the first cycle after reset release.
- **INIT duration:** exactly DEPTH cycles with cs=1. init_done_o rises the cycle after the last init write.
- **Read latency:** 1 cycle from the grant cycle to rsp_valid.
- **Throughput:** one access per cycle total. Back-to-back grants are allowed.
- **Reset mid-sweep or mid-read:** async reset clears rd_pend immediately. No response is issued and the sweep restarts from 0.
- **Re-init after a read grant:** a response due in the first INIT cycle is still delivered.

## Test plan
- **Reset sweep:** release reset -> 512 consecutive cycles with cs=1, we=1, addr 0..511, wdata=0, wstrb=32'hFFFFFFFF; init_done_o=1 on cycle 513; ready low until then.
- **Write then read:** req1 writes addr 9'h1A5 with data pattern P and strobes 32'h0000_00FF, then req1 reads 9'h1A5 -> rsp1_valid one cycle after the read grant; rdata low 8 bytes = P, upper 24 bytes = 0.
- **Contention:** both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each read response is routed to the correct port only.
- **Single requester:** only req1 valid for 4 cycles -> ready1 is high all 4 cycles; the pointer then favours 0 when both become valid.
- **Re-init:** pulse init_req_i while req0's read is granted -> that read's rsp0_valid still fires; a full 512-cycle zero sweep follows; a previously written address reads 0 afterwards.
- **Async reset mid-operation:** assert rst_i mid-sweep and mid-read -> outputs clear immediately, no response is issued, and the sweep restarts at addr 0.
